// File: rtl/entry_pkg.sv
// Shared types and constants for the keypad operand entry block.
package entry_pkg;

  localparam int DIGITS_DEFAULT = 3;

  typedef enum logic [1:0] {
    ENTER_A     = 2'd0,
    ENTER_B     = 2'd1,
    SHOW_RESULT = 2'd2
  } entry_state_e;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD shift buffer with digit counter; ENTRY_ROLL_EN lets a full buffer keep
// shifting (oldest digit dropped) instead of holding. DIGITS must be >= 2.
module bcd_entry_reg #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [3:0]            digit_i,
  output logic [4*DIGITS-1:0]   buf_o
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_s;

  assign full_s = (cnt_q == CW'(DIGITS));

  // next buffer/count: clear beats load beats shift
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      buf_d = {{(W-4){1'b0}}, digit_i};
      cnt_d = CW'(1);
    end else if (shift_i) begin
      if (!full_s) begin
        buf_d = {buf_q[W-5:0], digit_i};
        cnt_d = cnt_q + CW'(1);
      end else begin
`ifdef ENTRY_ROLL_EN
        buf_d = {buf_q[W-5:0], digit_i};
`else
        buf_d = buf_q;
`endif
      end
    end else begin
      buf_d = buf_q;
    end
  end

  // buffer and counter state
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o = buf_q;

endmodule

// File: rtl/operand_entry.sv
// Keypad-to-BCD operand entry: press detect, entry FSM and operand registers.
// Optional macro ENTRY_ROLL_EN: full entry buffer rolls instead of holding.
module operand_entry
  import entry_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [3:0]          key_code,
  input  logic                key_valid,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic                sum_req,
  output logic [4*DIGITS-1:0] entry_bcd,
  output logic                show_result,
  output logic [1:0]          entry_state
);

  localparam int W = 4 * DIGITS;

  entry_state_e state_q, state_d;
  logic         key_valid_q, press_q;
  logic [3:0]   code_q;
  logic [W-1:0] opa_q, opb_q, buf_s;
  logic         sum_q;
  logic         digit_s, commit_a_s, commit_b_s, clr_ops_s;
  logic         buf_clr_s, buf_load_s, buf_shift_s;

  // Edge detect is registered so the key acts one edge after it is first seen;
  // key_valid_q resets high so a key held through reset is never accepted.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      key_valid_q <= 1'b1;
      press_q     <= 1'b0;
      code_q      <= 4'h0;
    end else begin
      key_valid_q <= key_valid;
      press_q     <= key_valid & ~key_valid_q;
      code_q      <= key_code;
    end
  end

  assign digit_s = press_q & is_digit(code_q);

  // state register
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (press_q && code_q == KEY_CLR) begin
      state_d = ENTER_A;
    end else if (press_q) begin
      case (state_q)
        ENTER_A:     state_d = (code_q == KEY_ADD) ? ENTER_B : ENTER_A;
        ENTER_B:     state_d = (code_q == KEY_EQ) ? SHOW_RESULT : ENTER_B;
        SHOW_RESULT: state_d = digit_s ? ENTER_A : SHOW_RESULT;
        default:     state_d = ENTER_A;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // datapath control decoded from state and accepted key
  always_comb begin
    commit_a_s  = 1'b0;
    commit_b_s  = 1'b0;
    clr_ops_s   = 1'b0;
    buf_clr_s   = 1'b0;
    buf_load_s  = 1'b0;
    buf_shift_s = 1'b0;
    if (press_q && code_q == KEY_CLR) begin
      clr_ops_s = 1'b1;
      buf_clr_s = 1'b1;
    end else if (press_q) begin
      case (state_q)
        ENTER_A: begin
          buf_shift_s = digit_s;
          commit_a_s  = (code_q == KEY_ADD);
          buf_clr_s   = (code_q == KEY_ADD);
        end
        ENTER_B: begin
          buf_shift_s = digit_s;
          commit_b_s  = (code_q == KEY_EQ);
        end
        SHOW_RESULT: begin
          clr_ops_s  = digit_s;
          buf_load_s = digit_s;
        end
        default: begin
          clr_ops_s = 1'b1;
          buf_clr_s = 1'b1;
        end
      endcase
    end else begin
      buf_shift_s = 1'b0;
    end
  end

  // committed operands and the compute strobe
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      opa_q <= '0;
      opb_q <= '0;
      sum_q <= 1'b0;
    end else begin
      sum_q <= commit_b_s;
      if (clr_ops_s) begin
        opa_q <= '0;
        opb_q <= '0;
      end else begin
        if (commit_a_s) opa_q <= buf_s;
        if (commit_b_s) opb_q <= buf_s;
      end
    end
  end

  bcd_entry_reg #(.DIGITS(DIGITS)) u_buf (
    .clk     (clk),
    .n_reset (n_reset),
    .clr_i   (buf_clr_s),
    .load_i  (buf_load_s),
    .shift_i (buf_shift_s),
    .digit_i (code_q),
    .buf_o   (buf_s)
  );

  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign sum_req     = sum_q;
  assign show_result = (state_q == SHOW_RESULT);
  assign entry_state = state_q;
  assign entry_bcd   = (state_q == SHOW_RESULT) ? opb_q : buf_s;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: decimal-valued reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_operand_entry;

  localparam int DIGITS = 3;
  localparam int W      = 12;
  localparam int MAXV   = 1000;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [3:0]   key_code = 4'h0;
  logic         key_valid = 1'b0;
  logic [W-1:0] operand_a, operand_b, entry_bcd;
  logic         sum_req, show_result;
  logic [1:0]   entry_state;

  operand_entry #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .sum_req     (sum_req),
    .entry_bcd   (entry_bcd),
    .show_result (show_result),
    .entry_state (entry_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sum_cnt = 0;
  bit chk_en = 1'b0;

  // reference model: operands and buffer kept as plain decimal integers
  int         m_state = 0;
  int         m_a = 0, m_b = 0, m_v = 0, m_c = 0;
  bit         m_sum = 1'b0;
  bit         m_prev = 1'b1, m_pend = 1'b0;
  logic [3:0] m_code = 4'h0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_push(input int d);
    if (m_c < DIGITS) begin
      m_v = m_v * 10 + d;
      m_c++;
    end else begin
`ifdef ENTRY_ROLL_EN
      m_v = (m_v * 10 + d) % MAXV;
`endif
    end
  endtask

  task automatic m_key(input logic [3:0] k);
    int kv;
    kv = int'(k);
    if (k == 4'hC) begin
      m_a = 0; m_b = 0; m_v = 0; m_c = 0; m_state = 0;
    end else if (m_state == 0) begin
      if (kv <= 9) m_push(kv);
      else if (k == 4'hA) begin
        m_a = m_v; m_v = 0; m_c = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (kv <= 9) m_push(kv);
      else if (k == 4'hB) begin
        m_b = m_v; m_sum = 1'b1; m_state = 2;
      end
    end else begin
      if (kv <= 9) begin
        m_a = 0; m_b = 0; m_v = kv; m_c = 1; m_state = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!n_reset) begin
      m_state = 0; m_a = 0; m_b = 0; m_v = 0; m_c = 0;
      m_sum = 1'b0; m_prev = 1'b1; m_pend = 1'b0;
    end else begin
      m_sum = 1'b0;
      if (m_pend) m_key(m_code);
      m_pend = key_valid && !m_prev;
      m_code = key_code;
      m_prev = key_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("operand_a", 16'(operand_a), 16'(to_bcd(m_a)));
      check("operand_b", 16'(operand_b), 16'(to_bcd(m_b)));
      check("entry_bcd", 16'(entry_bcd), 16'(to_bcd(m_state == 2 ? m_b : m_v)));
      check("entry_state", 16'(entry_state), 16'(m_state));
      check("sum_req", 16'(sum_req), 16'(m_sum));
      check("show_result", 16'(show_result), 16'(m_state == 2));
    end
    if (sum_req === 1'b1) sum_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick(); tick();
    key_valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    int r, hold, gap;
    // key 5 held across reset and its release
    n_reset = 1'b0; key_code = 4'h5; key_valid = 1'b1;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    check("reset_entry", 16'(entry_bcd), 16'h000);
    check("reset_state", 16'(entry_state), 16'h0);
    n_reset = 1'b1;
    repeat (4) tick();
    check("held_through_reset", 16'(entry_bcd), 16'h000);
    key_valid = 1'b0;
    tick(); tick();
    press(4'h5);
    check("first_press", 16'(entry_bcd), 16'h005);
    press(4'hC);

    // 123 + 045
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    press(4'h4); press(4'h5);
    sum_cnt = 0;
    press(4'hB);
    check("lit_opa", 16'(operand_a), 16'h123);
    check("lit_opb", 16'(operand_b), 16'h045);
    check("lit_show", 16'(show_result), 16'h1);
    check("lit_sum_pulses", 16'(sum_cnt), 16'h1);

    // overflow behaviour
    press(4'hC);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
`ifdef ENTRY_ROLL_EN
    check("lit_full", 16'(entry_bcd), 16'h876);
`else
    check("lit_full", 16'(entry_bcd), 16'h987);
`endif

    // long hold with code changing underneath
    press(4'hC);
    key_code = 4'h3; key_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      key_code = (i % 4 < 2) ? 4'h7 : 4'h3;
    end
    key_valid = 1'b0;
    tick(); tick();
    check("lit_hold", 16'(entry_bcd), 16'h003);

    // CLEAR from ENTER_B
    press(4'hC);
    press(4'h4); press(4'hA); press(4'h4); press(4'h2);
    check("lit_b_state", 16'(entry_state), 16'h1);
    check("lit_b_entry", 16'(entry_bcd), 16'h042);
    press(4'hC);
    check("lit_clr_state", 16'(entry_state), 16'h0);
    check("lit_clr_opa", 16'(operand_a), 16'h000);
    check("lit_clr_entry", 16'(entry_bcd), 16'h000);

    // digit in SHOW_RESULT restarts entry
    press(4'h1); press(4'hA); press(4'h2); press(4'hB);
    check("lit_sr_state", 16'(entry_state), 16'h2);
    check("lit_sr_entry", 16'(entry_bcd), 16'h002);
    press(4'h6);
    check("lit_new_state", 16'(entry_state), 16'h0);
    check("lit_new_opa", 16'(operand_a), 16'h000);
    check("lit_new_opb", 16'(operand_b), 16'h000);
    check("lit_new_entry", 16'(entry_bcd), 16'h006);
    check("lit_new_show", 16'(show_result), 16'h0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        n_reset = 1'b0;
        key_valid = 1'($urandom_range(0, 1));
        key_code = 4'($urandom_range(0, 15));
        tick(); tick();
        n_reset = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
      end else begin
        key_code = (r < 65) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        key_valid = 1'b1;
        hold = int'($urandom_range(1, 4));
        for (int h = 0; h < hold; h++) begin
          tick();
          if ($urandom_range(0, 3) == 0) key_code = 4'($urandom_range(0, 15));
        end
        key_valid = 1'b0;
        gap = int'($urandom_range(1, 3));
        repeat (gap) tick();
      end
    end

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
